moore_botoes: RTL and testbench

Input conditioner for the up/down Moore counter. Takes the two raw, active-low board pushbuttons, synchronises and debounces them, and produces clean single-cycle `UP`/`DOWN` pulses, with optional auto-repeat while a button is held. Its outputs drive the `UP`/`DOWN` inputs of the next-state logic directly. That logic sits in front of a state register clocked every cycle, so any level longer than one cycle would advance the counter more than once.

---
 rtl/moore_botoes.sv | 113 +++++++++++
 tb/tb_moore_botoes.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/moore_botoes.sv
// Pushbutton conditioner: synchronise, debounce and turn each active-low key
// into single-cycle press pulses (with optional auto-repeat) for the Moore counter.
module moore_botoes_canal #(
    parameter int DEBOUNCE_CICLOS = 500000,
    parameter int REPEAT_CICLOS   = 0,
    parameter int W_CNT           = 20
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_pulso,
    output logic o_est
);
    localparam logic [W_CNT-1:0] DEB_MAX = W_CNT'(DEBOUNCE_CICLOS - 1);
    localparam logic [W_CNT-1:0] REP_MAX = W_CNT'((REPEAT_CICLOS == 0) ? 0 : REPEAT_CICLOS - 1);
    localparam logic [W_CNT-1:0] UM      = W_CNT'(1);

    logic [1:0]       r_sync;
    logic             r_est, r_est_d, r_pulso;
    logic [W_CNT-1:0] r_cnt, r_rcnt;

    logic             w_s, w_est_nxt, w_rise, w_rep, w_fire;
    logic [W_CNT-1:0] w_cnt_nxt, w_rcnt_nxt;

    assign w_s = r_sync[1];

    always_comb begin
        w_est_nxt = r_est;
        w_cnt_nxt = r_cnt;
        if (w_s == r_est) begin
            w_cnt_nxt = '0;
        end else if (r_cnt == DEB_MAX) begin
            w_est_nxt = w_s;
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + UM;
        end
    end

    // A repeat that would coincide with the release being accepted is dropped,
    // so no pulse ever appears while the debounced state reads released.
    assign w_rise = r_est & ~r_est_d;
    assign w_rep  = (REPEAT_CICLOS != 0) && r_est && w_est_nxt && (r_rcnt == REP_MAX);
    assign w_fire = w_rise | w_rep;

    always_comb begin
        w_rcnt_nxt = r_rcnt + UM;
        if (!r_est || w_fire || (REPEAT_CICLOS == 0))
            w_rcnt_nxt = '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync  <= '0;
            r_est   <= 1'b0;
            r_est_d <= 1'b0;
            r_cnt   <= '0;
            r_rcnt  <= '0;
            r_pulso <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], ~i_key_n};
            r_est   <= w_est_nxt;
            r_est_d <= r_est;
            r_cnt   <= w_cnt_nxt;
            r_rcnt  <= w_rcnt_nxt;
            r_pulso <= w_fire;
        end
    end

    assign o_pulso = r_pulso;
    assign o_est   = r_est;
endmodule

module moore_botoes #(
    parameter int DEBOUNCE_CICLOS = 500000,
    parameter int REPEAT_CICLOS   = 0,
    parameter int W_CNT           = 20
) (
    input  logic CLK,
    input  logic RST,
    input  logic KEY_UP,
    input  logic KEY_DOWN,
    output logic UP,
    output logic DOWN,
    output logic EST_UP,
    output logic EST_DOWN
);
    localparam int NUM_CH = 2;

    // Channel 0 = up, channel 1 = down; no arbitration between them.
    logic [NUM_CH-1:0] w_key_n, w_pulso, w_est;

    assign w_key_n = {KEY_DOWN, KEY_UP};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        moore_botoes_canal #(
            .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS),
            .REPEAT_CICLOS  (REPEAT_CICLOS),
            .W_CNT          (W_CNT)
        ) u_canal (
            .i_clk  (CLK),
            .i_rst  (RST),
            .i_key_n(w_key_n[g]),
            .o_pulso(w_pulso[g]),
            .o_est  (w_est[g])
        );
    end

    assign UP       = w_pulso[0];
    assign DOWN     = w_pulso[1];
    assign EST_UP   = w_est[0];
    assign EST_DOWN = w_est[1];
endmodule

// File: tb/tb_moore_botoes.sv
// Directed bench for moore_botoes: one instance without repeat, one with REPEAT_CICLOS=5.
module tb_moore_botoes;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic ku = 1'b1, kd = 1'b1, ku_r = 1'b1, kd_r = 1'b1;
    logic up, dn, eu, ed;
    logic up_r, dn_r, eu_r, ed_r;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;

    moore_botoes #(.DEBOUNCE_CICLOS(4), .REPEAT_CICLOS(0), .W_CNT(8)) dut (
        .CLK(CLK), .RST(RST), .KEY_UP(ku), .KEY_DOWN(kd),
        .UP(up), .DOWN(dn), .EST_UP(eu), .EST_DOWN(ed)
    );

    moore_botoes #(.DEBOUNCE_CICLOS(4), .REPEAT_CICLOS(5), .W_CNT(8)) dut_r (
        .CLK(CLK), .RST(RST), .KEY_UP(ku_r), .KEY_DOWN(kd_r),
        .UP(up_r), .DOWN(dn_r), .EST_UP(eu_r), .EST_DOWN(ed_r)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        #2 RST = 1'b1;
        #1;
        n_vec++;
        if ({up, dn, eu, ed, up_r, dn_r, eu_r, ed_r} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_async: outs=%b want 00000000", {up, dn, eu, ed, up_r, dn_r, eu_r, ed_r});
        end
        idle(2);
        RST = 1'b0;
        idle(8);
        n_vec++;
        if ({up, dn, eu, ed, up_r, dn_r, eu_r, ed_r} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_idle: outs=%b want 00000000", {up, dn, eu, ed, up_r, dn_r, eu_r, ed_r});
        end
    endtask

    task automatic test_clean_press();
        ku = 1'b0;
        for (int e = 0; e < 15; e++) begin
            tick();
            n_vec++;
            if (up !== (e == 6) || eu !== (e >= 5) || dn !== 1'b0) begin
                n_err++;
                $display("FAIL clean_press e=%0d: UP=%b EST_UP=%b DOWN=%b want UP=%b EST_UP=%b DOWN=0",
                         e, up, eu, dn, (e == 6), (e >= 5));
            end
        end
    endtask

    task automatic test_release();
        ku = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            n_vec++;
            if (eu !== (e < 5) || up !== 1'b0) begin
                n_err++;
                $display("FAIL release e=%0d: EST_UP=%b UP=%b want EST_UP=%b UP=0", e, eu, up, (e < 5));
            end
        end
    endtask

    task automatic test_bounce();
        for (int c = 0; c < 36; c++) begin
            kd = (c < 20) ? (((c / 2) % 2) == 1) : 1'b0;
            tick();
            n_vec++;
            if (dn !== (c == 26) || ed !== (c >= 25) || up !== 1'b0) begin
                n_err++;
                $display("FAIL bounce c=%0d: DOWN=%b EST_DOWN=%b UP=%b want DOWN=%b EST_DOWN=%b UP=0",
                         c, dn, ed, up, (c == 26), (c >= 25));
            end
        end
        kd = 1'b1;
        idle(12);
    endtask

    task automatic test_simultaneous();
        ku = 1'b0;
        kd = 1'b0;
        for (int e = 0; e < 10; e++) begin
            tick();
            n_vec++;
            if (up !== (e == 6) || dn !== (e == 6) || eu !== (e >= 5) || ed !== (e >= 5)) begin
                n_err++;
                $display("FAIL simultaneous e=%0d: UP=%b DOWN=%b EST_UP=%b EST_DOWN=%b want %b %b %b %b",
                         e, up, dn, eu, ed, (e == 6), (e == 6), (e >= 5), (e >= 5));
            end
        end
        ku = 1'b1;
        kd = 1'b1;
        idle(12);
        n_vec++;
        if (eu !== 1'b0 || ed !== 1'b0) begin
            n_err++;
            $display("FAIL simultaneous_release: EST_UP=%b EST_DOWN=%b want 0 0", eu, ed);
        end
    endtask

    task automatic test_auto_repeat();
        int  pulses;
        logic exp_up;
        pulses = 0;
        for (int c = 0; c < 45; c++) begin
            ku_r = (c >= 30);
            tick();
            exp_up = (c >= 6) && (c <= 31) && (((c - 6) % 5) == 0);
            if (up_r === 1'b1) pulses++;
            n_vec++;
            if (up_r !== exp_up || eu_r !== (c >= 5 && c < 35) || dn_r !== 1'b0) begin
                n_err++;
                $display("FAIL auto_repeat c=%0d: UP=%b EST_UP=%b DOWN=%b want UP=%b EST_UP=%b DOWN=0",
                         c, up_r, eu_r, dn_r, exp_up, (c >= 5 && c < 35));
            end
        end
        n_vec++;
        if (pulses != 6) begin
            n_err++;
            $display("FAIL auto_repeat_count: got %0d pulses want 6", pulses);
        end
    endtask

    task automatic test_reset_mid();
        ku = 1'b0;
        idle(7);
        n_vec++;
        if (up !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_pre: UP=%b want 1", up);
        end
        RST = 1'b1;
        #1;
        n_vec++;
        if ({up, dn, eu, ed} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_mid_async: UP/DOWN/EST_UP/EST_DOWN=%b want 0000", {up, dn, eu, ed});
        end
        idle(2);
        RST = 1'b0;
        for (int e = 0; e < 10; e++) begin
            tick();
            n_vec++;
            if (up !== (e == 6) || eu !== (e >= 5)) begin
                n_err++;
                $display("FAIL reset_mid_post e=%0d: UP=%b EST_UP=%b want UP=%b EST_UP=%b",
                         e, up, eu, (e == 6), (e >= 5));
            end
        end
        ku = 1'b1;
        idle(12);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_simultaneous();
        test_auto_repeat();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
